cpu_control_unit: RTL and testbench
===================================

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 4'h0: the program counter value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 8: the width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port run, input, 1 bit: level enable; 1 = fetch/execute, 0 = park in IDLE at the next instruction boundary.
REQ-006 SHALL have port instr, input, 8 bits: the instruction-ROM output for the current pc (combinational ROM, zero read latency).
REQ-007 SHALL have port pc, output, 4 bits: the instruction-ROM address.
REQ-008 SHALL have port ir, output, 8 bits: the latched instruction register; opcode = ir[7:4], operand = ir[3:0].
REQ-009 SHALL have port dmem_addr, output, 4 bits: the data-memory address, equal to ir[3:0].
REQ-010 SHALL have ports dmem_re and dmem_we, outputs, 1 bit each: the data-memory read and write strobes.
REQ-011 SHALL have ports rf_we, output, 1 bit (register write), and rf_sel, output, 1 bit (0 = R0, 1 = R1).
REQ-012 SHALL have port alu_en, output, 1 bit: selects the ALU result (R0+R1) as the register write data.
REQ-013 SHALL have ports state, output, 3 bits (the FSM state), halted, output, 1 bit, and retired, output, CNT_W bits.

Function
REQ-014 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3 and HALTED=4; the encodings 5-7 SHALL transition to IDLE.
REQ-015 SHALL transition IDLE->FETCH on a clock edge when run=1, and otherwise hold in IDLE.
REQ-016 In FETCH, SHALL load ir<=instr and pc<=pc+1 (modulo 16, so 15 wraps to 0), then go to DECODE.
REQ-017 SHALL go from DECODE to EXECUTE unconditionally.
REQ-018 In EXECUTE, SHALL go to HALTED if opcode is 1111, to FETCH if run=1, and to IDLE if run=0.
REQ-019 SHALL give each non-HALT instruction exactly 3 cycles (FETCH, DECODE, EXECUTE), with no overlap between instructions.
REQ-020 SHALL decode opcodes as follows: 0000 NOP; 0001 LOAD R0,[a]; 1001 LOAD R1,[a]; 0011 ADD R0,R1; 0010 STORE R0,[a]; 1111 HALT. All other opcodes SHALL execute as NOP.
REQ-021 For LOAD, SHALL assert dmem_re in DECODE and EXECUTE, and SHALL assert rf_we=1 with rf_sel=ir[7] in EXECUTE only.
REQ-022 For ADD, SHALL assert alu_en=1, rf_we=1 and rf_sel=0 in EXECUTE only.
REQ-023 For STORE, SHALL assert dmem_we=1 in EXECUTE only, for exactly one cycle.
REQ-024 SHALL drive all strobes to 0 in IDLE, FETCH and HALTED, and for NOP, HALT and undefined opcodes.
REQ-025 SHALL decode the strobes from state and ir only, never from instr.
REQ-026 SHALL increment retired by 1 on every EXECUTE->next transition, including HALT; at the all-ones value it SHALL saturate and not wrap.
REQ-027 SHALL hold halted=1 iff state is HALTED; HALTED SHALL be exited only by reset, and run SHALL be ignored there.
REQ-028 SHALL hold pc, ir and retired constant in IDLE and HALTED.
REQ-029 SHALL sample a run deassertion in FETCH or DECODE with no effect until the end of EXECUTE, so the current instruction always completes.

Reset
REQ-030 While rst_n=0, SHALL asynchronously force state=IDLE, pc=RESET_PC, ir=0, retired=0 and all strobes and halted to 0.
REQ-031 A reset asserted mid-instruction (e.g. in EXECUTE of a STORE) SHALL drop dmem_we immediately, without waiting for a clock edge.
REQ-032 After rst_n deasserts, the first FETCH SHALL occur on the first rising edge with run=1.

Verification
REQ-033 With ROM 11,92,30,23,F0 and run=1, the bench SHALL see: LOAD R0 at addr 1, LOAD R1 at addr 2, ADD, STORE at addr 3; then halted=1 after 15 cycles from the first FETCH, retired=5 and pc=5.
REQ-034 With all-NOP ROM and run=1 for 48 cycles, the bench SHALL see pc wrap 15->0, retired=16 and no strobe asserted.
REQ-035 Dropping run during DECODE of STORE (0x23) SHALL give one dmem_we pulse, then IDLE with pc held; reasserting run SHALL resume at the next pc.
REQ-036 Opcode 0x5 and 0xC SHALL produce no strobes and still increment retired.
REQ-037 Pulsing rst_n low in EXECUTE of STORE SHALL clear dmem_we asynchronously, with pc=0, state=0 and retired=0.
REQ-038 After HALT with run held at 1 for 10 cycles, pc, ir and retired SHALL be unchanged and halted=1.

Source files
------------

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
//   Multi-cycle control unit for a tiny accumulator-style CPU. Each instruction
//   takes three cycles (FETCH, DECODE, EXECUTE), and instructions never overlap.
//   HALT parks the machine in HALTED, and only reset leaves that state.
//   The datapath strobes are decoded only from the state and the latched IR.
//   They never depend on the instruction-ROM output, so they are glitch-free
//   relative to the ROM. They also fall asynchronously with rst_n, because
//   the state register resets asynchronously.
//
// Parameters
//   RESET_PC   pc value loaded on reset
//   CNT_W      width of the saturating retired-instruction counter
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   run                 1 = fetch/execute, 0 = park in IDLE at the next boundary
//   instr[7:0]          ROM data for the current pc (zero-latency ROM)
//   pc[3:0]             ROM address
//   ir[7:0]             instruction register (opcode ir[7:4], operand ir[3:0])
//   dmem_addr[3:0]      data-memory address (ir[3:0])
//   dmem_re, dmem_we    data-memory read / write strobes
//   rf_we, rf_sel       register write, target register (0 = R0, 1 = R1)
//   alu_en              register write data comes from the ALU (R0+R1)
//   state[2:0]          FSM state (IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, HALTED 4)
//   halted              1 while in HALTED
//   retired[CNT_W-1:0]  completed-instruction count, saturating
module cpu_control_unit #(
  parameter logic [3:0] RESET_PC = 4'h0,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [7:0]       instr,
  output logic [3:0]       pc,
  output logic [7:0]       ir,
  output logic [3:0]       dmem_addr,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             rf_sel,
  output logic             alu_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LD0   = 4'b0001;
  localparam logic [3:0] OP_LD1   = 4'b1001;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_ST    = 4'b0010;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic re;
    logic we;
    logic rf_we;
    logic rf_sel;
    logic alu_en;
  } ctl_t;

  state_t     st;
  logic [3:0] op;
  ctl_t       ctl;

  assign op = ir[7:4];

  // Sequencer: pc/ir move only in FETCH and retired only leaving EXECUTE, so
  // all three hold in IDLE and HALTED. A run drop seen in FETCH or DECODE is
  // acted on only at the end of EXECUTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= 8'h00;
      retired <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (run) st <= S_FETCH;
        end
        S_FETCH: begin
          ir <= instr;
          pc <= pc + 4'd1;         // natural 4-bit wrap 15 -> 0
          st <= S_DECODE;
        end
        S_DECODE: begin
          st <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (retired != CNT_MAX) retired <= retired + CNT_ONE;
          if (op == OP_HALT) st <= S_HALTED;
          else if (run)      st <= S_FETCH;
          else               st <= S_IDLE;
        end
        S_HALTED: begin
          st <= S_HALTED;          // only reset leaves HALTED
        end
        default: begin
          st <= S_IDLE;            // encodings 5..7 recover to IDLE
        end
      endcase
    end
  end

  // Strobe decode from the state and ir only. LOAD asserts its read strobe
  // one cycle early (in DECODE) so the memory data is valid for the
  // register write in EXECUTE.
  always_comb begin
    ctl = '0;
    case (st)
      S_DECODE: begin
        if (op == OP_LD0 || op == OP_LD1) ctl.re = 1'b1;
      end
      S_EXECUTE: begin
        case (op)
          OP_LD0, OP_LD1: begin
            ctl.re     = 1'b1;
            ctl.rf_we  = 1'b1;
            ctl.rf_sel = ir[7];
          end
          OP_ADD: begin
            ctl.alu_en = 1'b1;
            ctl.rf_we  = 1'b1;
          end
          OP_ST: begin
            ctl.we = 1'b1;
          end
          OP_NOP, OP_HALT: ;
          default: ;               // undefined opcodes behave as NOP
        endcase
      end
      default: ;
    endcase
  end

  assign dmem_re   = ctl.re;
  assign dmem_we   = ctl.we;
  assign rf_we     = ctl.rf_we;
  assign rf_sel    = ctl.rf_sel;
  assign alu_en    = ctl.alu_en;
  assign dmem_addr = ir[3:0];
  assign state     = st;
  assign halted    = (st == S_HALTED);

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] instr;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [3:0] dmem_addr;
  logic       dmem_re, dmem_we, rf_we, rf_sel, alu_en;
  logic [2:0] state;
  logic       halted;
  logic [7:0] retired;

  logic [7:0] rom [16];
  assign instr = rom[pc];

  always #5 clk = ~clk;

  cpu_control_unit #(.RESET_PC(4'h0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .pc(pc), .ir(ir),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .rf_we(rf_we), .rf_sel(rf_sel), .alu_en(alu_en), .state(state),
    .halted(halted), .retired(retired)
  );

  int n_cmp = 0;
  int n_err = 0;
  int we_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the machine's phase within an instruction plus the
  // architectural registers, advanced one clock at a time.
  int         m_phase;   // 0 idle, 1 fetch, 2 decode, 3 execute, 4 halted
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  int         m_ret;

  task automatic model_reset();
    m_phase = 0; m_pc = 4'h0; m_ir = 8'h00; m_ret = 0;
  endtask

  task automatic model_step(input logic r);
    case (m_phase)
      0: if (r) m_phase = 1;
      1: begin m_ir = rom[m_pc]; m_pc = 4'((int'(m_pc) + 1) % 16); m_phase = 2; end
      2: m_phase = 3;
      3: begin
        if (m_ret < 255) m_ret++;
        if (m_ir[7:4] == 4'hF) m_phase = 4;
        else m_phase = r ? 1 : 0;
      end
      default: m_phase = 4;
    endcase
  endtask

  task automatic check_all();
    int  op;
    bit  is_ld, ex;
    op    = int'(m_ir[7:4]);
    is_ld = (op == 1) || (op == 9);
    ex    = (m_phase == 3);
    chk("state",     32'(state),     32'(m_phase));
    chk("pc",        32'(pc),        32'(m_pc));
    chk("ir",        32'(ir),        32'(m_ir));
    chk("retired",   32'(retired),   32'(m_ret));
    chk("halted",    32'(halted),    32'(m_phase == 4));
    chk("dmem_addr", 32'(dmem_addr), 32'(m_ir[3:0]));
    chk("dmem_re",   32'(dmem_re),   32'(is_ld && (m_phase == 2 || ex)));
    chk("dmem_we",   32'(dmem_we),   32'(ex && op == 2));
    chk("rf_we",     32'(rf_we),     32'(ex && (is_ld || op == 3)));
    chk("rf_sel",    32'(rf_sel),    32'(ex && op == 9));
    chk("alu_en",    32'(alu_en),    32'(ex && op == 3));
  endtask

  task automatic step(input logic r);
    @(negedge clk);
    run = r;
    #1;
    check_all();
    if (dmem_we) we_pulses++;
    @(posedge clk);
    model_step(r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic rom_fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    rom_fill(8'h00);
    model_reset();

    // Program: LOAD R0,[1]; LOAD R1,[2]; ADD; STORE [3]; HALT
    rom[0] = 8'h11; rom[1] = 8'h92; rom[2] = 8'h30; rom[3] = 8'h23; rom[4] = 8'hF0;
    do_reset();
    step(1'b1);                          // IDLE -> first FETCH
    for (int i = 0; i < 14; i++) step(1'b1);
    chk("prog_not_halted_early", 32'(halted), 32'd0);
    step(1'b1);
    @(negedge clk); #1;
    chk("prog_halted", 32'(halted), 32'd1);
    chk("prog_retired", 32'(retired), 32'd5);
    chk("prog_pc", 32'(pc), 32'd5);
    // HALTED ignores run
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("halt_pc", 32'(pc), 32'd5);
    chk("halt_ir", 32'(ir), 32'hF0);
    chk("halt_retired", 32'(retired), 32'd5);
    chk("halt_halted", 32'(halted), 32'd1);

    // All-NOP ROM: 16 instructions, pc wraps back to 0
    rom_fill(8'h00);
    do_reset();
    for (int i = 0; i < 49; i++) step(1'b1);
    @(negedge clk); #1;
    chk("nop_retired", 32'(retired), 32'd16);
    chk("nop_pc_wrap", 32'(pc), 32'd0);

    // run dropped during DECODE of STORE: one pulse, then IDLE with pc held
    rom_fill(8'h00);
    rom[0] = 8'h23; rom[1] = 8'h11;
    do_reset();
    we_pulses = 0;
    step(1'b1); step(1'b1);              // FETCH, now DECODE
    step(1'b0); step(1'b0);              // DECODE, EXECUTE with run low
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("drop_we_pulses", 32'(we_pulses), 32'd1);
    chk("drop_idle", 32'(state), 32'd0);
    chk("drop_pc_held", 32'(pc), 32'd1);
    step(1'b1); step(1'b1);
    @(negedge clk); #1;
    chk("resume_ir", 32'(ir), 32'h11);

    // Undefined opcodes 0x5 and 0xC act as NOP but still retire
    rom_fill(8'h00);
    rom[0] = 8'h5A; rom[1] = 8'hC7; rom[2] = 8'hF0;
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1);
    @(negedge clk); #1;
    chk("undef_retired", 32'(retired), 32'd2);

    // Async reset in EXECUTE of STORE
    rom_fill(8'h00);
    rom[0] = 8'h23;
    do_reset();
    step(1'b1); step(1'b1); step(1'b1);  // now in EXECUTE
    @(negedge clk); #1;
    chk("arst_we_before", 32'(dmem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(dmem_we), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Retired counter saturates at all-ones
    rom_fill(8'h00);
    do_reset();
    step(1'b1);
    for (int i = 0; i < 3 * 260; i++) step(1'b1);
    @(negedge clk); #1;
    chk("sat_retired", 32'(retired), 32'd255);

    // Randomized programs with a randomly toggling run
    for (int t = 0; t < 8; t++) begin
      logic [7:0] ops [7];
      ops = '{8'h0, 8'h1, 8'h9, 8'h3, 8'h2, 8'hF, 8'h5};
      for (int i = 0; i < 16; i++) begin
        logic [7:0] o;
        if ($urandom_range(0, 9) == 0) o = 8'($urandom_range(0, 15));
        else o = ops[$urandom_range(0, 5)];
        if (o == 8'hF && $urandom_range(0, 3) != 0) o = 8'h2;
        rom[i] = {o[3:0], 4'($urandom_range(0, 15))};
      end
      do_reset();
      for (int i = 0; i < 70; i++) step($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
